// File: rtl/apb_pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pwm_multi
//  Description : APB3 multi-channel PWM with a shared prescaler and period
//                counter, per-channel duty, and period-boundary shadow loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_pwm_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [31:0]       PADDR,
    input  logic              PWRITE,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] PWM_OUT,
    output logic              IRQ
);

    localparam logic [7:0]         C_OFF_CTRL   = 8'h00;
    localparam logic [7:0]         C_OFF_PRESC  = 8'h04;
    localparam logic [7:0]         C_OFF_PERIOD = 8'h08;
    localparam logic [7:0]         C_OFF_STATUS = 8'h0C;
    localparam logic [7:0]         C_OFF_DUTY0  = 8'h10;
    localparam logic [PRESC_W-1:0] C_PONE       = PRESC_W'(1);
    localparam logic [CNT_W-1:0]   C_CONE       = CNT_W'(1);

    // Programmer-visible registers
    logic                r_gen;
    logic                r_ie;
    logic [NUM_CH-1:0]   r_en;
    logic [PRESC_W-1:0]  r_presc;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    r_duty [NUM_CH];
    logic                r_wrap;

    // Shadows, counters and outputs
    logic [CNT_W-1:0]    r_period_s;
    logic [CNT_W-1:0]    r_duty_s [NUM_CH];
    logic [PRESC_W-1:0]  r_pcnt;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_CH-1:0]   r_pwm;

    logic [7:0]          w_off;
    logic [5:0]          w_duty_idx;
    logic                w_aligned;
    logic                w_is_ctrl;
    logic                w_is_presc;
    logic                w_is_period;
    logic                w_is_status;
    logic                w_is_duty;
    logic                w_err;
    logic                w_access;
    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_wr_presc;
    logic                w_wr_period;
    logic                w_wr_status;
    logic                w_wr_duty;
    logic                w_tick;
    logic                w_wrap_evt;
    logic                w_gen_rise;
    logic                w_load;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_off       = PADDR[7:0];
    assign w_duty_idx  = w_off[7:2] - 6'd4;
    assign w_aligned   = (w_off[1:0] == 2'b00);
    assign w_is_ctrl   = (w_off == C_OFF_CTRL);
    assign w_is_presc  = (w_off == C_OFF_PRESC);
    assign w_is_period = (w_off == C_OFF_PERIOD);
    assign w_is_status = (w_off == C_OFF_STATUS);
    assign w_is_duty   = w_aligned && (w_off >= C_OFF_DUTY0) && (w_duty_idx < 6'(NUM_CH));
    assign w_err       = !w_aligned ||
                         !(w_is_ctrl || w_is_presc || w_is_period || w_is_status || w_is_duty);

    assign w_access    = PSEL & PENABLE;
    assign w_wr        = w_access & PWRITE & ~w_err;
    assign w_wr_ctrl   = w_wr & w_is_ctrl;
    assign w_wr_presc  = w_wr & w_is_presc;
    assign w_wr_period = w_wr & w_is_period;
    assign w_wr_status = w_wr & w_is_status;
    assign w_wr_duty   = w_wr & w_is_duty;

    // ------------------------------------------------------------------
    // Timebase events
    // ------------------------------------------------------------------
    assign w_tick     = r_gen & (r_pcnt == r_presc);
    assign w_wrap_evt = w_tick & (r_cnt == r_period_s);
    assign w_gen_rise = w_wr_ctrl & PWDATA[0] & ~r_gen;
    assign w_load     = w_gen_rise | w_wrap_evt;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_gen    <= 1'b0;
            r_ie     <= 1'b0;
            r_en     <= '0;
            r_presc  <= '0;
            r_period <= '1;
            r_wrap   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_gen <= PWDATA[0];
                r_ie  <= PWDATA[1];
                r_en  <= PWDATA[8 +: NUM_CH];
            end
            if (w_wr_presc) begin
                r_presc <= PWDATA[PRESC_W-1:0];
            end
            if (w_wr_period) begin
                r_period <= PWDATA[CNT_W-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr_duty && (w_duty_idx == 6'(i))) begin
                    r_duty[i] <= PWDATA[CNT_W-1:0];
                end
            end
            // A wrap on the same edge as a clear must leave the flag set
            if (w_wrap_evt) begin
                r_wrap <= 1'b1;
            end else if (w_wr_status && PWDATA[0]) begin
                r_wrap <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and period counter
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
        end else if (!r_gen) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
            r_cnt  <= w_wrap_evt ? '0 : (r_cnt + C_CONE);
        end else begin
            // Free-running increment lets pcnt wrap through its maximum when
            // PRESC is lowered below the current count.
            r_pcnt <= r_pcnt + C_PONE;
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers and output compare
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_period_s <= '1;
            r_pwm      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_s[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_period_s <= r_period;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_load) begin
                    r_duty_s[i] <= r_duty[i];
                end
                r_pwm[i] <= r_gen & r_en[i] & (r_cnt < r_duty_s[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_is_ctrl) begin
            w_rdata[0]           = r_gen;
            w_rdata[1]           = r_ie;
            w_rdata[8 +: NUM_CH] = r_en;
        end else if (w_is_presc) begin
            w_rdata = 32'(r_presc);
        end else if (w_is_period) begin
            w_rdata = 32'(r_period);
        end else if (w_is_status) begin
            w_rdata[0] = r_wrap;
        end else if (w_is_duty) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_duty_idx == 6'(i)) begin
                    w_rdata = 32'(r_duty[i]);
                end
            end
        end
    end

    assign PRDATA   = (w_access && !PWRITE && !w_err) ? w_rdata : 32'd0;
    assign PSLVERR  = w_access & w_err;
    assign PREADY   = 1'b1;
    assign PWM_OUT  = r_pwm;
    assign IRQ      = r_wrap & r_ie;

    assign w_unused = &{1'b0, PADDR[31:8], PWDATA};

endmodule
`default_nettype wire

// File: tb/tb_apb_pwm_multi.sv
`default_nettype none
// Testbench for apb_pwm_multi: directed scenarios plus randomized APB traffic
// checked against a behavioural model of the peripheral.
module tb_apb_pwm_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 16;
    localparam logic [31:0] C_CMASK = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0] C_PMASK = 32'((64'd1 << PRESC_W) - 64'd1);

    logic              PCLK    = 1'b0;
    logic              PRESETn = 1'b0;
    logic [31:0]       PADDR   = 32'd0;
    logic              PWRITE  = 1'b0;
    logic              PSEL    = 1'b0;
    logic              PENABLE = 1'b0;
    logic [31:0]       PWDATA  = 32'd0;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NUM_CH-1:0] PWM_OUT;
    logic              IRQ;

    int   n_cmp  = 0;
    int   n_err  = 0;
    logic chk_en = 1'b0;

    apb_pwm_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PWM_OUT (PWM_OUT),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    logic              m_gen, m_ie, m_wrap;
    logic [NUM_CH-1:0] m_en, m_pwm;
    logic [31:0]       m_presc, m_period, m_period_s, m_pcnt, m_cnt;
    logic [31:0]       m_duty   [NUM_CH];
    logic [31:0]       m_duty_s [NUM_CH];

    function automatic bit exp_err(input logic [31:0] a);
        int off;
        off = int'(a[7:0]);
        if (off % 4 != 0) return 1'b1;
        if (off < 16) return 1'b0;
        return ((off - 16) / 4) >= NUM_CH;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int off;
        off = int'(a[7:0]);
        if (exp_err(a)) return 32'd0;
        case (off)
            0:       return {16'd0, 8'(m_en), 6'd0, m_ie, m_gen};
            4:       return m_presc;
            8:       return m_period;
            12:      return {31'd0, m_wrap};
            default: return m_duty[(off - 16) / 4];
        endcase
    endfunction

    task automatic model_reset();
        m_gen = 1'b0; m_ie = 1'b0; m_wrap = 1'b0;
        m_en = '0; m_pwm = '0;
        m_presc = 32'd0; m_period = C_CMASK; m_period_s = C_CMASK;
        m_pcnt = 32'd0; m_cnt = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 32'd0;
            m_duty_s[i] = 32'd0;
        end
    endtask

    task automatic model_step();
        bit wr, tick, wrap, start;
        int off;
        off   = int'(PADDR[7:0]);
        wr    = PSEL && PENABLE && PWRITE && !exp_err(PADDR);
        tick  = m_gen && (m_pcnt == m_presc);
        wrap  = tick && (m_cnt == m_period_s);
        start = wr && (off == 0) && PWDATA[0] && !m_gen;
        for (int i = 0; i < NUM_CH; i++)
            m_pwm[i] = m_gen && m_en[i] && (m_cnt < m_duty_s[i]);
        if (start || wrap) begin
            m_period_s = m_period;
            for (int i = 0; i < NUM_CH; i++) m_duty_s[i] = m_duty[i];
        end
        if (!m_gen) begin
            m_pcnt = 32'd0;
            m_cnt  = 32'd0;
        end else if (tick) begin
            m_pcnt = 32'd0;
            m_cnt  = wrap ? 32'd0 : m_cnt + 32'd1;
        end else begin
            m_pcnt = (m_pcnt + 32'd1) & C_PMASK;
        end
        if (wrap) m_wrap = 1'b1;
        else if (wr && off == 12 && PWDATA[0]) m_wrap = 1'b0;
        if (wr) begin
            case (off)
                0: begin
                    m_gen = PWDATA[0];
                    m_ie  = PWDATA[1];
                    m_en  = PWDATA[8 +: NUM_CH];
                end
                4:  m_presc  = PWDATA & C_PMASK;
                8:  m_period = PWDATA & C_CMASK;
                12: ;
                default: m_duty[(off - 16) / 4] = PWDATA & C_CMASK;
            endcase
        end
    endtask

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) model_reset();
        else          model_step();
    end

    always @(negedge PCLK) begin
        if (chk_en && PRESETn) begin
            check_eq("pwm", 32'(PWM_OUT), 32'(m_pwm));
            check_eq("irq", 32'(IRQ), 32'(m_wrap & m_ie));
            check_eq("pready", 32'(PREADY), 32'd1);
        end
    end

    // ------------------------------------------------------------------
    // APB drivers
    // ------------------------------------------------------------------
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 check_eq("wr_slverr", 32'(PSLVERR), 32'(exp_err(a)));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        d = PRDATA;
        e = PSLVERR;
        check_eq("rd_data", d, m_read(a));
        check_eq("rd_slverr", 32'(e), 32'(exp_err(a)));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] d;
        logic        e;
        for (int i = 0; i < 4 + NUM_CH; i++) begin
            apb_read(32'(4 * i), d, e);
            check_eq(tag, d, (i == 2) ? C_CMASK : 32'd0);
        end
    endtask

    task automatic wait_irq(input logic val, input int lim);
        for (int k = 0; k < lim; k++) begin
            @(negedge PCLK);
            if (IRQ === val) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a, d;
        logic        e;
        int          sel, hi0, hi1, hi2;
        int          hist [30];

        repeat (3) @(posedge PCLK);
        #2;
        check_eq("rst_pwm_out", 32'(PWM_OUT), 32'd0);
        check_eq("rst_irq", 32'(IRQ), 32'd0);
        check_eq("rst_prdata", PRDATA, 32'd0);
        check_eq("rst_pslverr", 32'(PSLVERR), 32'd0);
        check_eq("rst_pready", 32'(PREADY), 32'd1);
        PRESETn = 1'b1;
        chk_en  = 1'b1;

        check_reset_regs("rst_regval");

        // Error responses leave the register file untouched
        apb_read(32'h3C, d, e);
        check_eq("err_rd_3c", 32'(e), 32'd1);
        apb_read(32'h20, d, e);
        check_eq("err_rd_duty4", 32'(e), 32'd1);
        apb_write(32'h02, 32'hFFFF_FFFF);
        apb_read(32'h00, d, e);
        check_eq("err_ctrl_kept", d, 32'd0);
        apb_read(32'h04, d, e);
        check_eq("err_presc_kept", d, 32'd0);
        check_eq("prdata_idle", PRDATA, 32'd0);

        // 3-of-10 waveform on channel 0
        apb_write(32'h04, 32'd0);
        apb_write(32'h08, 32'd9);
        apb_write(32'h10, 32'd3);
        apb_write(32'h00, 32'h101);
        apb_read(32'h0C, d, e);
        check_eq("s1_wrap_early", d, 32'd0);
        hi0 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (PWM_OUT[0]) hi0++;
        end
        check_eq("s1_high_count", 32'(hi0), 32'd6);
        apb_read(32'h0C, d, e);
        check_eq("s1_wrap_set", d, 32'd1);

        // Duty 0 stays low, duty above period stays high
        apb_write(32'h00, 32'h0);
        apb_write(32'h04, 32'd1);
        apb_write(32'h08, 32'd3);
        apb_write(32'h14, 32'd0);
        apb_write(32'h18, 32'd5);
        apb_write(32'h00, 32'h601);
        repeat (2) @(negedge PCLK);
        hi1 = 0; hi2 = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge PCLK);
            if (PWM_OUT[1]) hi1++;
            if (PWM_OUT[2]) hi2++;
        end
        check_eq("s2_ch1_low", 32'(hi1), 32'd0);
        check_eq("s2_ch2_high", 32'(hi2), 32'd16);

        // Mid-period duty update only takes effect next period
        apb_write(32'h00, 32'h0);
        apb_write(32'h04, 32'd0);
        apb_write(32'h08, 32'd9);
        apb_write(32'h10, 32'd2);
        apb_write(32'h00, 32'h101);
        fork
            apb_write(32'h10, 32'd7);
            for (int k = 0; k < 30; k++) begin
                @(negedge PCLK);
                hist[k] = int'(PWM_OUT[0]);
            end
        join
        hi0 = 0; hi1 = 0;
        for (int k = 1; k <= 10; k++)  hi0 += hist[k];
        for (int k = 11; k <= 20; k++) hi1 += hist[k];
        check_eq("s3_width_cur", 32'(hi0), 32'd2);
        check_eq("s3_width_next", 32'(hi1), 32'd7);

        // Interrupt set, set-wins-over-clear, and clear
        apb_write(32'h00, 32'h103);
        apb_write(32'h0C, 32'd1);
        if (IRQ) apb_write(32'h0C, 32'd1);
        wait_irq(1'b1, 40);
        check_eq("irq_on_wrap", 32'(IRQ), 32'd1);
        repeat (7) @(posedge PCLK);
        apb_write(32'h0C, 32'd1);
        check_eq("irq_set_wins", 32'(IRQ), 32'd1);
        apb_write(32'h0C, 32'd1);
        check_eq("irq_cleared", 32'(IRQ), 32'd0);
        apb_read(32'h0C, d, e);
        check_eq("status_cleared", d, 32'd0);

        // Asynchronous reset in the middle of a high phase
        for (int k = 0; k < 30; k++) begin
            @(negedge PCLK);
            if (PWM_OUT[0]) break;
        end
        check_eq("pre_rst_pwm_high", 32'(PWM_OUT[0]), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check_eq("mid_rst_pwm", 32'(PWM_OUT), 32'd0);
        check_eq("mid_rst_irq", 32'(IRQ), 32'd0);
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        check_reset_regs("mid_rst_regval");

        // Randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            sel = int'($urandom_range(0, 10));
            case (sel)
                0: begin
                    d = ($urandom & 32'hFFFF_FF02) | 32'($urandom_range(0, 3) != 0);
                    apb_write(32'h00, d);
                end
                1: apb_write(32'h04, 32'($urandom_range(0, 3)));
                2: apb_write(32'h08, 32'($urandom_range(0, 12)) | ($urandom_range(0, 3) == 0 ? 32'hA5A5_0000 : 32'd0));
                3: apb_write(32'h0C, $urandom);
                4, 5: begin
                    a = 32'h10 + 32'(4 * $urandom_range(0, NUM_CH - 1));
                    d = 32'($urandom_range(0, 14)) | ($urandom_range(0, 3) == 0 ? 32'h5A5A_0000 : 32'd0);
                    apb_write(a, d);
                end
                6: apb_write(32'($urandom_range(0, 63)) | ($urandom & 32'hFFFF_FF00), 32'($urandom_range(0, 15)));
                7, 8, 9: apb_read(32'($urandom_range(0, 63)), d, e);
                default: begin
                    repeat ($urandom_range(1, 8)) @(posedge PCLK);
                    #1 check_eq("prdata_idle_rand", PRDATA, 32'd0);
                end
            endcase
        end

        repeat (4) @(posedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
